// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type codes and per-VC framing state.
package noc_pkg;

  localparam int FLIT_W  = 34;
  localparam int VC_ID_W = 2;

  localparam logic [1:0] FT_HEAD   = 2'b00;
  localparam logic [1:0] FT_BODY   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b11;
  localparam logic [1:0] FT_SINGLE = 2'b10;

  typedef enum logic {
    FS_IDLE  = 1'b0,
    FS_INPKT = 1'b1
  } frame_state_e;

  function automatic frame_state_e frame_next(input frame_state_e s, input logic [1:0] ft);
    frame_next = ((ft == FT_HEAD) || (ft == FT_BODY && s == FS_INPKT)) ? FS_INPKT : FS_IDLE;
  endfunction

  // HEAD/SINGLE are only legal between packets; BODY/TAIL only inside one.
  function automatic logic frame_err(input frame_state_e s, input logic [1:0] ft);
    if (s == FS_IDLE) frame_err = (ft == FT_BODY) || (ft == FT_TAIL);
    else              frame_err = (ft == FT_HEAD) || (ft == FT_SINGLE);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a pointer that advances past each winner.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic       found;

  // Two passes over constant indices: first [ptr..N-1], then the wrapped part [0..ptr-1].
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int v = 0; v < N; v++) begin
      if (en && !found && req[v] && (2'(v) >= ptr_q)) begin
        gnt[v] = 1'b1;
        found  = 1'b1;
        ptr_d  = 2'((v + 1) % N);
      end
    end
    for (int v = 0; v < N; v++) begin
      if (en && !found && req[v] && (2'(v) < ptr_q)) begin
        gnt[v] = 1'b1;
        found  = 1'b1;
        ptr_d  = 2'((v + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vc_link_tx.sv
// Link transmitter: round-robin flit interleave of N_VC streams into one registered link stage,
// with a per-VC packet framing checker on every granted flit.
module vc_link_tx
  import noc_pkg::*;
#(
  parameter int N_VC   = 2,
  parameter int FLIT_W = 34
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [N_VC*FLIT_W-1:0] fdata_vc_i,
  input  logic [N_VC-1:0]        valid_vc_i,
  output logic [N_VC-1:0]        ready_vc_o,
  output logic [FLIT_W-1:0]      fdata_o,
  output logic [1:0]             vc_id_o,
  output logic                   valid_o,
  input  logic [N_VC-1:0]        ready_i,
  output logic                   proto_err_o
);

  logic [FLIT_W-1:0] fdata_q, fdata_d, fdata_sel;
  logic [1:0]        vc_id_q, vc_id_d, vc_sel;
  logic              valid_q, valid_d;
  logic              err_q, err_d, err_sel;
  logic [3:0]        ready_pad;
  logic              loadable, gnt_any;
  logic [N_VC-1:0]   gnt;
  frame_state_e      fs_q [N_VC];
  frame_state_e      fs_d [N_VC];

  // Register frees up when empty or when its flit leaves on the link this cycle.
  always_comb begin
    ready_pad            = '0;
    ready_pad[N_VC-1:0]  = ready_i;
    loadable             = !valid_q || ready_pad[vc_id_q];
  end

  rr_arbiter #(.N(N_VC)) u_arb (
    .clk  (clk),
    .arst (arst),
    .req  (valid_vc_i & ready_i),
    .en   (loadable && !arst),
    .gnt  (gnt)
  );

  assign ready_vc_o = gnt;
  assign gnt_any    = |gnt;

  always_comb begin
    fdata_sel = '0;
    vc_sel    = '0;
    err_sel   = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      fs_d[v] = fs_q[v];
      if (gnt[v]) begin
        fdata_sel = fdata_vc_i[v*FLIT_W +: FLIT_W];
        vc_sel    = 2'(v);
        err_sel   = frame_err(fs_q[v], fdata_vc_i[v*FLIT_W + FLIT_W - 1 -: 2]);
        fs_d[v]   = frame_next(fs_q[v], fdata_vc_i[v*FLIT_W + FLIT_W - 1 -: 2]);
      end
    end
  end

  always_comb begin
    fdata_d = fdata_q;
    vc_id_d = vc_id_q;
    valid_d = valid_q;
    err_d   = gnt_any && err_sel;
    if (loadable) begin
      valid_d = gnt_any;
      if (gnt_any) begin
        fdata_d = fdata_sel;
        vc_id_d = vc_sel;
      end
    end
  end

  // Output stage
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      fdata_q <= '0;
      vc_id_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int v = 0; v < N_VC; v++) fs_q[v] <= FS_IDLE;
    end else begin
      fdata_q <= fdata_d;
      vc_id_q <= vc_id_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      for (int v = 0; v < N_VC; v++) fs_q[v] <= fs_d[v];
    end
  end

  assign fdata_o     = fdata_q;
  assign vc_id_o     = vc_id_q;
  assign valid_o     = valid_q;
  assign proto_err_o = err_q;

endmodule

// File: tb/tb_vc_link_tx.sv
// Directed bench for vc_link_tx: table of vectors on a 2-VC instance plus reset and 4-VC wrap sequences.
module tb_vc_link_tx;

  localparam int FW = 34;
  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b11, S = 2'b10;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  logic [2*FW-1:0] fd2;
  logic [1:0]      vv2, rdy2, rvc2, vc2;
  logic [FW-1:0]   fo2;
  logic            vo2, err2;

  logic [4*FW-1:0] fd4;
  logic [3:0]      vv4, rdy4, rvc4;
  logic [1:0]      vc4;
  logic [FW-1:0]   fo4;
  logic            vo4, err4;

  vc_link_tx #(.N_VC(2), .FLIT_W(FW)) dut2 (
    .clk(clk), .arst(arst), .fdata_vc_i(fd2), .valid_vc_i(vv2), .ready_vc_o(rvc2),
    .fdata_o(fo2), .vc_id_o(vc2), .valid_o(vo2), .ready_i(rdy2), .proto_err_o(err2));

  vc_link_tx #(.N_VC(4), .FLIT_W(FW)) dut4 (
    .clk(clk), .arst(arst), .fdata_vc_i(fd4), .valid_vc_i(vv4), .ready_vc_o(rvc4),
    .fdata_o(fo4), .vc_id_o(vc4), .valid_o(vo4), .ready_i(rdy4), .proto_err_o(err4));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] p);
    return {t, p};
  endfunction

  typedef struct {
    logic [1:0]    vv;
    logic [1:0]    rdy;
    logic [FW-1:0] d0;
    logic [FW-1:0] d1;
    logic [1:0]    rvc;
    logic          ev;
    logic [1:0]    evc;
    logic [FW-1:0] ed;
    logic          eerr;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] vv, input logic [1:0] rdy,
                              input logic [FW-1:0] d0, input logic [FW-1:0] d1,
                              input logic [1:0] rvc, input logic ev, input logic [1:0] evc,
                              input logic [FW-1:0] ed, input logic eerr);
    vec_t r;
    r.vv = vv; r.rdy = rdy; r.d0 = d0; r.d1 = d1; r.rvc = rvc;
    r.ev = ev; r.evc = evc; r.ed = ed; r.eerr = eerr;
    return r;
  endfunction

  vec_t tbl [21];

  initial begin
    arst = 1'b1;
    fd2 = '0; vv2 = '0; rdy2 = '0;
    fd4 = '0; vv4 = '0; rdy4 = '0;

    tbl[0]  = mk(2'b10, 2'b11, '0,           fl(H, 32'h11), 2'b10, 1, 1, fl(H, 32'h11), 0);
    tbl[1]  = mk(2'b10, 2'b11, '0,           fl(B, 32'h12), 2'b10, 1, 1, fl(B, 32'h12), 0);
    tbl[2]  = mk(2'b10, 2'b11, '0,           fl(T, 32'h13), 2'b10, 1, 1, fl(T, 32'h13), 0);
    tbl[3]  = mk(2'b11, 2'b11, fl(H, 32'h20), fl(H, 32'h30), 2'b01, 1, 0, fl(H, 32'h20), 0);
    tbl[4]  = mk(2'b11, 2'b11, fl(B, 32'h21), fl(H, 32'h30), 2'b10, 1, 1, fl(H, 32'h30), 0);
    tbl[5]  = mk(2'b11, 2'b11, fl(B, 32'h21), fl(T, 32'h31), 2'b01, 1, 0, fl(B, 32'h21), 0);
    tbl[6]  = mk(2'b11, 2'b11, fl(T, 32'h22), fl(T, 32'h31), 2'b10, 1, 1, fl(T, 32'h31), 0);
    tbl[7]  = mk(2'b01, 2'b11, fl(T, 32'h22), '0,           2'b01, 1, 0, fl(T, 32'h22), 0);
    tbl[8]  = mk(2'b00, 2'b11, '0,           '0,           2'b00, 0, 0, '0,            0);
    tbl[9]  = mk(2'b01, 2'b11, fl(H, 32'h40), '0,           2'b01, 1, 0, fl(H, 32'h40), 0);
    tbl[10] = mk(2'b01, 2'b10, fl(B, 32'h41), '0,           2'b00, 1, 0, fl(H, 32'h40), 0);
    tbl[11] = mk(2'b11, 2'b10, fl(B, 32'h41), fl(S, 32'h50), 2'b00, 1, 0, fl(H, 32'h40), 0);
    tbl[12] = mk(2'b11, 2'b10, fl(B, 32'h41), fl(S, 32'h50), 2'b00, 1, 0, fl(H, 32'h40), 0);
    tbl[13] = mk(2'b01, 2'b11, fl(B, 32'h41), '0,           2'b01, 1, 0, fl(B, 32'h41), 0);
    tbl[14] = mk(2'b01, 2'b11, fl(H, 32'h42), '0,           2'b01, 1, 0, fl(H, 32'h42), 1);
    tbl[15] = mk(2'b01, 2'b11, fl(T, 32'h43), '0,           2'b01, 1, 0, fl(T, 32'h43), 0);
    tbl[16] = mk(2'b01, 2'b11, fl(B, 32'h44), '0,           2'b01, 1, 0, fl(B, 32'h44), 1);
    tbl[17] = mk(2'b10, 2'b11, '0,           fl(S, 32'h51), 2'b10, 1, 1, fl(S, 32'h51), 0);
    tbl[18] = mk(2'b10, 2'b11, '0,           fl(T, 32'h52), 2'b10, 1, 1, fl(T, 32'h52), 1);
    tbl[19] = mk(2'b11, 2'b00, fl(H, 32'h45), fl(H, 32'h53), 2'b00, 1, 1, fl(T, 32'h52), 0);
    tbl[20] = mk(2'b00, 2'b11, '0,           '0,           2'b00, 0, 1, '0,            0);

    // Reset state
    #2;
    chk("rst_valid", 64'(vo2), 64'h0);
    chk("rst_vc_id", 64'(vc2), 64'h0);
    chk("rst_err",   64'(err2), 64'h0);
    chk("rst_fdata", 64'(fo2), 64'h0);
    @(negedge clk);
    arst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      vv2  = tbl[i].vv;
      rdy2 = tbl[i].rdy;
      fd2  = {tbl[i].d1, tbl[i].d0};
      #1;
      chk($sformatf("v%0d_ready_vc", i), 64'(rvc2), 64'(tbl[i].rvc));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(vo2), 64'(tbl[i].ev));
      chk($sformatf("v%0d_vc_id", i), 64'(vc2), 64'(tbl[i].evc));
      chk($sformatf("v%0d_err", i),   64'(err2), 64'(tbl[i].eerr));
      if (tbl[i].ev) chk($sformatf("v%0d_fdata", i), 64'(fo2), 64'(tbl[i].ed));
    end

    // Asynchronous reset in the middle of a VC1 packet
    @(negedge clk);
    vv2 = 2'b10; rdy2 = 2'b11; fd2 = {fl(H, 32'h60), {FW{1'b0}}};
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 64'(vo2), 64'h1);
    chk("pre_rst_vc_id", 64'(vc2), 64'h1);
    @(negedge clk);
    fd2 = {fl(B, 32'h61), {FW{1'b0}}};
    #2;
    arst = 1'b1;
    #1;
    chk("arst_valid", 64'(vo2), 64'h0);
    chk("arst_vc_id", 64'(vc2), 64'h0);
    chk("arst_err",   64'(err2), 64'h0);
    chk("arst_fdata", 64'(fo2), 64'h0);
    chk("arst_ready_vc", 64'(rvc2), 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 64'(vo2), 64'h0);
    @(negedge clk);
    arst = 1'b0;
    #1;
    chk("post_rst_ready_vc", 64'(rvc2), 64'h2);
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(vo2), 64'h1);
    chk("post_rst_vc_id", 64'(vc2), 64'h1);
    chk("post_rst_fdata", 64'(fo2), 64'(fl(B, 32'h61)));
    chk("post_rst_err",   64'(err2), 64'h1);
    @(negedge clk);
    vv2 = '0;

    // 4-VC wrap: all eligible, then only VC3, then all again
    rdy4 = 4'b1111;
    for (int v = 0; v < 4; v++) fd4[v*FW +: FW] = fl(S, 32'h70 + 32'(v));
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_vc;
      if (k < 4)       begin vv4 = 4'b1111; exp_vc = 2'(k); end
      else if (k == 4) begin vv4 = 4'b1000; exp_vc = 2'd3; end
      else             begin vv4 = 4'b1111; exp_vc = 2'd0; end
      #1;
      chk($sformatf("w%0d_ready_vc", k), 64'(rvc4), 64'(4'b0001 << exp_vc));
      @(posedge clk);
      #1;
      chk($sformatf("w%0d_valid", k), 64'(vo4), 64'h1);
      chk($sformatf("w%0d_vc_id", k), 64'(vc4), 64'(exp_vc));
      chk($sformatf("w%0d_fdata", k), 64'(fo4), 64'(fl(S, 32'h70 + 32'(exp_vc))));
      chk($sformatf("w%0d_err", k),   64'(err4), 64'h0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
